// File: rtl/ofm_pkg.sv
// rtl/ofm_pkg.sv - shared state encoding and AXI constants for the OFM write master
package ofm_pkg;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_AW   = 3'd1;
  localparam logic [2:0] ST_W    = 3'd2;
  localparam logic [2:0] ST_B    = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  localparam int BEAT_BYTES  = 64;
  localparam int BEAT_SHIFT  = 6;
  localparam int BOUNDARY_4K = 4096;

endpackage

// File: rtl/ofm_burst_calc.sv
// rtl/ofm_burst_calc.sv - burst length: min(beats_left, MAX_BURST, beats to next 4 KB boundary)
module ofm_burst_calc
  import ofm_pkg::*;
#(
  parameter int ADDR_W    = 64,
  parameter int MAX_BURST = 16
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       beats_left,
  output logic [8:0]        len
);

  localparam logic [8:0] MAX_LEN = 9'(MAX_BURST);

  logic [12:0] bytes_to_4k;
  logic [8:0]  beats_to_4k;
  logic        unused_addr_hi;

  // Only the page offset matters; the address is always beat aligned here.
  assign unused_addr_hi = ^addr[ADDR_W-1:12];

  always_comb begin
    bytes_to_4k = 13'(BOUNDARY_4K) - {1'b0, addr[11:0]};
    beats_to_4k = 9'(bytes_to_4k >> BEAT_SHIFT);
    len = MAX_LEN;
    if (beats_left < 32'(len)) len = beats_left[8:0];
    if (beats_to_4k < len) len = beats_to_4k;
  end

endmodule

// File: rtl/ofm_axi_wr_master.sv
// rtl/ofm_axi_wr_master.sv - OFM stream to AXI4 write bursts, one request outstanding
// Optional OFM_WR_STAT_EN adds saturating beat/burst/stall counters.
module ofm_axi_wr_master
  import ofm_pkg::*;
#(
  parameter int ADDR_W    = 64,
  parameter int DATA_W    = 512,
  parameter int MAX_BURST = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wmst_req,
  input  logic [ADDR_W-1:0]   wmst_addr,
  input  logic [ADDR_W-1:0]   wmst_xfer_size,
  output logic                wmst_done,
  output logic                wmst_err,
`ifdef OFM_WR_STAT_EN
  output logic [31:0]         stat_beats,
  output logic [31:0]         stat_bursts,
  output logic [31:0]         stat_stall,
`endif
  input  logic [DATA_W-1:0]   s_tdata,
  input  logic                s_tvalid,
  output logic                s_tready,
  output logic [ADDR_W-1:0]   m_awaddr,
  output logic [7:0]          m_awlen,
  output logic [2:0]          m_awsize,
  output logic [1:0]          m_awburst,
  output logic                m_awvalid,
  input  logic                m_awready,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  output logic                m_wlast,
  output logic                m_wvalid,
  input  logic                m_wready,
  input  logic [1:0]          m_bresp,
  input  logic                m_bvalid,
  output logic                m_bready
);

  logic [2:0]        state, state_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       beats_left_q;
  logic [31:0]       beats_after;
  logic [8:0]        len_q;
  logic [8:0]        beat_cnt_q;
  logic [8:0]        calc_len;
  logic              err_q;
  logic              in_w;

  ofm_burst_calc #(.ADDR_W(ADDR_W), .MAX_BURST(MAX_BURST)) u_burst_calc (
    .addr       (addr_q),
    .beats_left (beats_left_q),
    .len        (calc_len)
  );

  assign beats_after = beats_left_q - 32'(len_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // A zero-size request passes through AW without raising AWVALID, so done lands two cycles after the request.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (wmst_req) state_nxt = ST_AW;
      ST_AW: begin
        if (beats_left_q == 32'd0) state_nxt = ST_DONE;
        else if (m_awready)        state_nxt = ST_W;
      end
      ST_W:    if (m_wvalid && m_wready && beat_cnt_q == 9'd1) state_nxt = ST_B;
      ST_B:    if (m_bvalid) state_nxt = (beats_after == 32'd0) ? ST_DONE : ST_AW;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    in_w      = (state == ST_W);
    m_awvalid = (state == ST_AW) && (beats_left_q != 32'd0);
    m_awaddr  = m_awvalid ? addr_q : '0;
    m_awlen   = m_awvalid ? 8'(calc_len - 9'd1) : 8'd0;
    m_awsize  = 3'($clog2(DATA_W / 8));
    m_awburst = AXI_BURST_INCR;
    m_wdata   = in_w ? s_tdata : '0;
    m_wvalid  = in_w && s_tvalid;
    m_wlast   = in_w && (beat_cnt_q == 9'd1);
    m_wstrb   = '1;
    s_tready  = in_w && m_wready;
    m_bready  = (state == ST_B);
    wmst_done = (state == ST_DONE);
    wmst_err  = err_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q       <= '0;
      beats_left_q <= '0;
      len_q        <= '0;
      beat_cnt_q   <= '0;
      err_q        <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (wmst_req) begin
          addr_q       <= wmst_addr & ~ADDR_W'(BEAT_BYTES - 1);
          beats_left_q <= 32'(wmst_xfer_size >> BEAT_SHIFT)
                          + {31'd0, |wmst_xfer_size[BEAT_SHIFT-1:0]};
          err_q        <= |wmst_addr[BEAT_SHIFT-1:0];
        end
        ST_AW: if (m_awvalid && m_awready) begin
          len_q      <= calc_len;
          beat_cnt_q <= calc_len;
        end
        ST_W: if (m_wvalid && m_wready) beat_cnt_q <= beat_cnt_q - 9'd1;
        ST_B: if (m_bvalid) begin
          if (m_bresp != AXI_RESP_OKAY) err_q <= 1'b1;
          addr_q       <= addr_q + (ADDR_W'(len_q) << BEAT_SHIFT);
          beats_left_q <= beats_after;
        end
        default: ;
      endcase
    end
  end

`ifdef OFM_WR_STAT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_beats  <= '0;
      stat_bursts <= '0;
      stat_stall  <= '0;
    end else begin
      if (m_wvalid && m_wready && stat_beats != 32'hFFFF_FFFF)
        stat_beats <= stat_beats + 32'd1;
      if (m_awvalid && m_awready && stat_bursts != 32'hFFFF_FFFF)
        stat_bursts <= stat_bursts + 32'd1;
      if (in_w && m_wready && !s_tvalid && stat_stall != 32'hFFFF_FFFF)
        stat_stall <= stat_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ofm_axi_wr_master.sv
// tb/tb_ofm_axi_wr_master.sv - directed bench with a burst-plan model and per-handshake checker
module tb_ofm_axi_wr_master;

  typedef struct {
    logic [63:0] addr;
    logic [7:0]  len;
  } aw_t;

  logic         clk;
  logic         rst_n;
  logic         wmst_req;
  logic [63:0]  wmst_addr;
  logic [63:0]  wmst_xfer_size;
  logic         wmst_done;
  logic         wmst_err;
  logic [511:0] s_tdata;
  logic         s_tvalid;
  logic         s_tready;
  logic [63:0]  m_awaddr;
  logic [7:0]   m_awlen;
  logic [2:0]   m_awsize;
  logic [1:0]   m_awburst;
  logic         m_awvalid;
  logic         m_awready;
  logic [511:0] m_wdata;
  logic [63:0]  m_wstrb;
  logic         m_wlast;
  logic         m_wvalid;
  logic         m_wready;
  logic [1:0]   m_bresp;
  logic         m_bvalid;
  logic         m_bready;
`ifdef OFM_WR_STAT_EN
  logic [31:0]  stat_beats, stat_bursts, stat_stall;
  logic [31:0]  sb0, sbu0, ss0;
`endif

  int n_chk = 0;
  int n_fail = 0;
  int cyc;
  int word_seq;
  int plan_base, plan_words;
  aw_t exp_aw[$];
  logic [511:0] exp_w[$];
  int aw_cnt, aw_cyc0, w_cyc0, w_last_cyc, beat_idx;
  logic [7:0] cur_len;

  ofm_axi_wr_master #(.ADDR_W(64), .DATA_W(512), .MAX_BURST(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .wmst_req(wmst_req), .wmst_addr(wmst_addr), .wmst_xfer_size(wmst_xfer_size),
    .wmst_done(wmst_done), .wmst_err(wmst_err),
`ifdef OFM_WR_STAT_EN
    .stat_beats(stat_beats), .stat_bursts(stat_bursts), .stat_stall(stat_stall),
`endif
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize), .m_awburst(m_awburst),
    .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast), .m_wvalid(m_wvalid),
    .m_wready(m_wready), .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [511:0] mk_word(input int k);
    logic [511:0] w;
    for (int i = 0; i < 16; i++) w[i*32 +: 32] = 32'hC0DE_0000 + 32'(k * 16 + i);
    return w;
  endfunction

  function automatic logic bitof(input logic [31:0] m, input int c);
    return (c >= 0 && c < 32) ? m[c] : 1'b0;
  endfunction

  // Expected AXI traffic from the request alone: split into bursts, never crossing 4 KB.
  task automatic plan(input logic [63:0] addr, input logic [63:0] size);
    logic [63:0] a, beats, to4k, l;
    aw_t e;
    a = addr & ~64'h3F;
    beats = (size + 64'd63) / 64'd64;
    plan_base = word_seq;
    plan_words = int'(beats);
    word_seq += plan_words;
    while (beats != 0) begin
      to4k = (64'd4096 - (a % 64'd4096)) / 64'd64;
      l = beats;
      if (l > 64'd16) l = 64'd16;
      if (l > to4k) l = to4k;
      e.addr = a;
      e.len = 8'(l - 64'd1);
      exp_aw.push_back(e);
      a += l * 64'd64;
      beats -= l;
    end
    for (int i = 0; i < plan_words; i++) exp_w.push_back(mk_word(plan_base + i));
  endtask

  always @(negedge clk) begin
    aw_t e;
    if (rst_n && wmst_req) begin
      aw_cnt = 0; aw_cyc0 = -1; w_cyc0 = -1; w_last_cyc = -1; beat_idx = 0;
    end
    if (rst_n && m_awvalid && m_awready) begin
      if (exp_aw.size() == 0) chk("aw_unexpected", 1, 0);
      else begin
        e = exp_aw.pop_front();
        chk("awaddr", m_awaddr, e.addr);
        chk("awlen", m_awlen, e.len);
        chk("aw_const", {m_awsize, m_awburst}, {3'd6, 2'b01});
        cur_len = e.len;
      end
      beat_idx = 0;
      if (aw_cnt == 0) aw_cyc0 = cyc;
      aw_cnt++;
    end
    if (rst_n && m_wvalid && m_wready) begin
      if (exp_w.size() == 0) chk("w_unexpected", 1, 0);
      else begin
        chk("wdata", m_wdata, exp_w.pop_front());
        chk("wlast", m_wlast, beat_idx == int'(cur_len));
        chk("wstrb", m_wstrb, {64{1'b1}});
      end
      beat_idx++;
      if (w_cyc0 < 0) w_cyc0 = cyc;
      w_last_cyc = cyc;
    end
  end

  task automatic xfer(input logic [63:0] addr, input logic [63:0] size,
                      input logic [31:0] aw_off, input logic [31:0] tv_off,
                      input logic [31:0] wr_off, input int err_burst, input int abort_cyc,
                      output int done_cyc, output logic err_done,
                      output logic err_c1, output logic aw_seen);
    int next_word, pend_b, b_cnt, done_cnt;
    next_word = 0; pend_b = 0; b_cnt = 0; done_cnt = 0;
    done_cyc = -1; err_done = 1'b0; err_c1 = 1'b0; aw_seen = 1'b0;
    @(posedge clk); #1;
    cyc = 0;
    wmst_addr = addr;
    wmst_xfer_size = size;
    while (cyc < 300) begin
      wmst_req  = (cyc == 0);
      m_awready = !bitof(aw_off, cyc);
      m_wready  = !bitof(wr_off, cyc);
      s_tvalid  = (next_word < plan_words) && !bitof(tv_off, cyc);
      s_tdata   = (next_word < plan_words) ? mk_word(plan_base + next_word) : '0;
      m_bvalid  = (pend_b > 0);
      m_bresp   = (b_cnt == err_burst) ? 2'b10 : 2'b00;
      @(negedge clk);
      if (cyc == abort_cyc) begin
        chk("abort_in_w", m_wvalid, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("rst_ctrl", {m_awvalid, m_wvalid, m_wlast, s_tready, m_bready, wmst_done, wmst_err}, 0);
        chk("rst_aw_fields", {m_awaddr, m_awlen}, 0);
        chk("rst_wdata", m_wdata, 0);
        exp_aw.delete();
        exp_w.delete();
        s_tvalid = 1'b0;
        m_bvalid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        return;
      end
      if (m_awvalid) aw_seen = 1'b1;
      if (cyc == 1) err_c1 = wmst_err;
      if (s_tvalid && s_tready) next_word++;
      if (m_wvalid && m_wready && m_wlast) pend_b++;
      if (m_bvalid && m_bready) begin pend_b--; b_cnt++; end
      if (wmst_done) begin
        done_cnt++;
        if (done_cyc < 0) begin done_cyc = cyc; err_done = wmst_err; end
      end
      if (done_cyc >= 0 && cyc == done_cyc + 1) break;
      @(posedge clk); #1;
      cyc++;
    end
    s_tvalid = 1'b0;
    m_bvalid = 1'b0;
    chk("done_pulse", done_cnt, 1);
    chk("aw_drained", exp_aw.size(), 0);
    chk("w_drained", exp_w.size(), 0);
  endtask

  initial begin
    int dc;
    logic ed, e1, aws;
    rst_n = 1'b0; wmst_req = 1'b0; wmst_addr = '0; wmst_xfer_size = '0;
    s_tvalid = 1'b0; s_tdata = '0; m_awready = 1'b1; m_wready = 1'b1;
    m_bvalid = 1'b0; m_bresp = 2'b00; word_seq = 0; cyc = 0;
    plan_base = 0; plan_words = 0; cur_len = 8'd0;
    repeat (2) @(negedge clk);
    chk("reset_ctrl", {m_awvalid, m_wvalid, m_wlast, s_tready, m_bready, wmst_done, wmst_err}, 0);
    chk("reset_aw_fields", {m_awaddr, m_awlen}, 0);
    chk("reset_const", {m_awsize, m_awburst}, {3'd6, 2'b01});
    chk("reset_wstrb", m_wstrb, {64{1'b1}});
    @(posedge clk); #1;
    rst_n = 1'b1;

    plan(64'h1000, 64'd128);
    xfer(64'h1000, 64'd128, 0, 0, 0, -1, -1, dc, ed, e1, aws);
    chk("t1_aw_cycle", aw_cyc0, 1);
    chk("t1_w_first", w_cyc0, 2);
    chk("t1_w_last", w_last_cyc, 3);
    chk("t1_done_cycle", dc, 5);
    chk("t1_bursts", aw_cnt, 1);
    chk("t1_err", ed, 1'b0);

    plan(64'h0, 64'd1280);
    chk("t2_model_n", exp_aw.size(), 2);
    chk("t2_model_b0", {exp_aw[0].addr, exp_aw[0].len}, {64'h0, 8'd15});
    chk("t2_model_b1", {exp_aw[1].addr, exp_aw[1].len}, {64'h400, 8'd3});
    xfer(64'h0, 64'd1280, 32'h2, 0, 0, -1, -1, dc, ed, e1, aws);
    chk("t2_bursts", aw_cnt, 2);
    chk("t2_err", ed, 1'b0);

    plan(64'hFC0, 64'd192);
    chk("t3_model_b0", {exp_aw[0].addr, exp_aw[0].len}, {64'hFC0, 8'd0});
    chk("t3_model_b1", {exp_aw[1].addr, exp_aw[1].len}, {64'h1000, 8'd1});
    xfer(64'hFC0, 64'd192, 0, 0, 0, -1, -1, dc, ed, e1, aws);
    chk("t3_bursts", aw_cnt, 2);

`ifdef OFM_WR_STAT_EN
    sb0 = stat_beats; sbu0 = stat_bursts; ss0 = stat_stall;
`endif
    plan(64'h2000, 64'd320);
    xfer(64'h2000, 64'd320, 0, 32'h18, 32'hC0, -1, -1, dc, ed, e1, aws);
    chk("t4_w_first", w_cyc0, 2);
    chk("t4_w_last", w_last_cyc, 10);
    chk("t4_done_cycle", dc, 12);
`ifdef OFM_WR_STAT_EN
    chk("t4_stat_beats", stat_beats - sb0, 32'd5);
    chk("t4_stat_bursts", stat_bursts - sbu0, 32'd1);
    chk("t4_stat_stall", stat_stall - ss0, 32'd2);
`endif

    plan(64'h3000, 64'd1152);
    xfer(64'h3000, 64'd1152, 0, 0, 0, 0, -1, dc, ed, e1, aws);
    chk("t5_bursts", aw_cnt, 2);
    chk("t5_err_at_done", ed, 1'b1);
    repeat (3) @(negedge clk);
    chk("t5_err_sticky", wmst_err, 1'b1);

    plan(64'h1010, 64'd64);
    chk("t6_model_b0", {exp_aw[0].addr, exp_aw[0].len}, {64'h1000, 8'd0});
    xfer(64'h1010, 64'd64, 0, 0, 0, -1, -1, dc, ed, e1, aws);
    chk("t6_misalign_err", ed, 1'b1);

    plan(64'h40, 64'd64);
    xfer(64'h40, 64'd64, 0, 0, 0, -1, -1, dc, ed, e1, aws);
    chk("t7_err_cleared", e1, 1'b0);
    chk("t7_err_at_done", ed, 1'b0);

    plan(64'h5000, 64'd0);
    xfer(64'h5000, 64'd0, 0, 0, 0, -1, -1, dc, ed, e1, aws);
    chk("t8_zero_done_cycle", dc, 2);
    chk("t8_zero_no_awvalid", aws, 1'b0);

    plan(64'h6000, 64'd256);
    xfer(64'h6000, 64'd256, 0, 0, 0, -1, 3, dc, ed, e1, aws);

    plan(64'h7000, 64'd128);
    xfer(64'h7000, 64'd128, 0, 0, 0, -1, -1, dc, ed, e1, aws);
    chk("t10_aw_cycle", aw_cyc0, 1);
    chk("t10_done_cycle", dc, 5);
    chk("t10_err", ed, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ofm_axi_wr_master.md
Name: ofm_axi_wr_master

Overview:
- Write-master stage directly downstream of the OFM flattening/FIFO stage.
- Accepts a one-cycle write request carrying a byte address and transfer size. Pulls 512-bit words from the upstream valid/ready stream and emits AXI4 write bursts (AW/W/B).
- Pulses a done strobe back to the requester when all B responses have returned.
- Feeds the shell's memory interconnect. One request is outstanding at a time.

Parameters:
- ADDR_W, 64, AXI address and request-field width.
- DATA_W, 512, data width in bits; beat = DATA_W/8 = 64 bytes.
- MAX_BURST, 16, maximum beats per AXI burst (1..256).

Ports:
- clk  in  1  single clock
- rst_n  in  1  asynchronous active-low reset
- wmst_req  in  1  one-cycle request pulse
- wmst_addr  in  ADDR_W  start byte address
- wmst_xfer_size  in  ADDR_W  bytes to write
- wmst_done  out  1  one-cycle completion pulse
- wmst_err  out  1  sticky: non-OKAY BRESP or misaligned address; cleared by the next accepted request
- s_tdata  in  DATA_W  upstream word
- s_tvalid  in  1  upstream word valid
- s_tready  out  1  word consumed when s_tvalid and s_tready are both high
- m_awaddr  out  ADDR_W
- m_awlen  out  8
- m_awsize  out  3  constant log2(DATA_W/8)
- m_awburst  out  2  constant INCR (01)
- m_awvalid  out  1
- m_awready  in  1
- m_wdata  out  DATA_W
- m_wstrb  out  DATA_W/8  all ones
- m_wlast  out  1
- m_wvalid  out  1
- m_wready  in  1
- m_bresp  in  2
- m_bvalid  in  1
- m_bready  out  1

Behaviour:
- Reset values: all outputs 0, except the constant fields m_awsize, m_awburst and m_wstrb. State is IDLE and all counters are 0.
- Request acceptance:
  - wmst_req is sampled only in IDLE and ignored in every other state.
  - On acceptance, latch addr and size; compute beats_left = ceil(size/64) in a 32-bit field; clear wmst_err.
  - If addr[5:0] != 0, set wmst_err and align the address down to a 64-byte boundary.
- States: IDLE -> AW -> W -> B -> (AW | DONE) -> IDLE.
- Burst length:
  - Computed on entry to AW: len = min(beats_left, MAX_BURST, beats to next 4 KB boundary).
  - m_awlen = len-1.
  - m_awaddr = current address.
  - m_awvalid stays high until m_awready.
- AW: on the handshake, go to W. m_awvalid drops the cycle after the handshake.
- W:
  - Combinational pass-through: m_wdata = s_tdata, m_wvalid = s_tvalid, s_tready = m_wready, all only while in W. s_tready is 0 in every other state.
  - Each W handshake decrements the beat-in-burst count.
  - m_wlast is high on the final beat of the burst.
  - After the last beat, go to B.
- B:
  - m_bready = 1.
  - On bvalid: if bresp != 00, set wmst_err; add len*64 to the address and subtract len from beats_left.
  - If beats_left is then 0, go to DONE; otherwise go to AW.
- DONE: wmst_done = 1 for exactly one cycle, then IDLE. A new request is accepted no earlier than the cycle after done.
- Zero size: a request with size 0 goes IDLE -> DONE with no AXI traffic; done is pulsed 2 cycles after the request.
- Latency: with an always-ready slave and valid upstream data, a 2-beat request gives AW at cycle 1, W at cycles 2–3, B at cycle 4 or later, and done on the cycle after B.
- Upstream stall (s_tvalid=0) inserts W bubbles. AXI permits this; no beat is dropped or duplicated.
- Reset mid-transfer forces IDLE immediately. Outstanding AXI transactions are abandoned; the system resets the interconnect together with this block.

Optional Feature:
- Macro: OFM_WR_STAT_EN.
- When defined, add three 32-bit output ports:
  - stat_beats: W handshakes.
  - stat_bursts: AW handshakes.
  - stat_stall: cycles in W with m_wready=1 and s_tvalid=0.
- The counters reset only on rst_n and saturate at 0xFFFF_FFFF.
- When not defined, the ports and logic are absent and behaviour is otherwise identical.

Decomposition:
- Shared package (ofm_pkg): state encoding localparams, AXI_BURST_INCR = 2'b01, AXI_RESP_OKAY = 2'b00, BEAT_BYTES = 64, BOUNDARY_4K = 4096.
- One sub-module: ofm_burst_calc, combinational, taking addr and beats_left and producing len with the 4 KB and MAX_BURST clipping.

Test Plan:
- req addr=0x1000, size=128, slave always ready, words A,B -> one AW (addr 0x1000, len 1), W A then B with wlast on B, BRESP OKAY -> one done pulse, err=0.
- req addr=0x0, size=1280 (20 beats), MAX_BURST=16 -> two bursts: len 15 at 0x0, then len 3 at 0x400; done after the second B.
- req addr=0xFC0, size=192 -> 4 KB split: len 0 at 0xFC0, then len 1 at 0x1000; 3 beats total.
- s_tvalid toggling 1,0,0,1 and m_wready low for 2 cycles mid-burst -> data order is preserved, no loss or duplication; stat_stall counts only the s_tvalid-low cycles (with OFM_WR_STAT_EN).
- BRESP=2'b10 on the first burst -> wmst_err=1 sticky, transfer still completes, done pulses; the next req clears err.
- size=0 -> done exactly 2 cycles after req with no AWVALID; rst_n asserted in W -> all outputs 0 and state IDLE the same cycle.
